alu_op_controller: RTL and testbench
====================================

# alu_op_controller

Sequencing controller for the board-level arithmetic/logic unit and its 7-segment result display. Collects operand A, operand B and an operation code from the switches, one button press per field. Drives the combinational ALU, captures its N+1-bit result and holds it for display. Supports chaining: the previous result becomes the next A operand.

## Interface
- `N`, default 3: operand width; must match the ALU's `N`.
- `CNT_W`, default 8: width of the completed-operation counter.

- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `btn_next`  in  1  level, already debounced and synchronized; a rising edge is one "press".
- `btn_clear`  in  1  level, already synchronized; while high, forces abort to LOAD_A.
- `chain`  in  1  sampled on a press in SHOW; 1 = reuse the result as A.
- `sw_data`  in  N  operand value from switches.
- `sw_op`  in  4  operation: bit 3 = arithmetic(1)/logic(0), bits 2:0 = ALU selector.
- `alu_result`  in  N+1  combinational ALU output; bit N = carry, meaningful only for arithmetic selector 000.
- `alu_a`, `alu_b`  out  N  registered operands to the ALU.
- `alu_sel`  out  3  registered ALU selector.
- `alu_arith`  out  1  registered arithmetic/logic select.
- `result`  out  N+1  captured result, feeds the display decoder.
- `result_valid`  out  1  high while `result` holds a completed operation.
- `state_code`  out  3  current state encoding, for a status digit.
- `op_count`  out  CNT_W  completed operations, saturating.

## Operation
- States and encodings: LOAD_A=0, LOAD_B=1, LOAD_OP=2, EXEC=3, SHOW=4. Encodings 5–7 are illegal and go to LOAD_A on the next cycle.
- Press detection: `press = btn_next & ~prev`, where `prev` is a register of `btn_next`. A held button gives exactly one press.
- LOAD_A, on press: `alu_a <= sw_data`; go to LOAD_B.
- LOAD_B, on press: `alu_b <= sw_data`; go to LOAD_OP.
- LOAD_OP, on press: `alu_arith <= sw_op[3]`, `alu_sel <= sw_op[2:0]`, `result_valid <= 0`; go to EXEC.
- EXEC (exactly one cycle, no press needed):
  - `result <= alu_result`, `result_valid <= 1`.
  - `op_count` increments, saturating at 2^CNT_W−1.
  - Go to SHOW.
- SHOW, on press:
  - `chain=1`: `alu_a <= result[N-1:0]` (carry discarded); go to LOAD_B.
  - `chain=0`: go to LOAD_A.
  - `result` and `result_valid` hold in both cases until the next LOAD_OP press.
- Presses in EXEC are ignored.
- Clear, when `btn_clear`=1 in any state:
  - Next state LOAD_A.
  - `alu_a`, `alu_b`, `alu_sel`, `alu_arith`, `result` set to 0; `result_valid` set to 0.
  - `op_count` unchanged; only `rst` clears it.
- Clear and press in the same cycle: clear wins and the press is discarded.
- Clear in EXEC: no capture and no count.
- No illegal opcodes: all 16 `sw_op` values pass through unchanged. The carry interpretation is the ALU's responsibility.

## Timing
- Reset values:
  - State LOAD_A; `state_code` = 0.
  - All data outputs 0; `result_valid` = 0; `op_count` = 0.
  - `prev` = 1, so a button held through reset does not press.
- All outputs are registered; none is combinational from inputs.
- A press on cycle t is visible in the registered fields and `state_code` at t+1.
- Latency from the LOAD_OP press (cycle t) to result:
  - Operands/opcode at ALU at t+1, which is EXEC.
  - `result`/`result_valid` valid at t+2; state SHOW at t+2.
- `alu_result` must settle within one clock; it is sampled only at the end of EXEC.
- Reset mid-operation: all state lost, same as power-up.

## Structure
- Package `alu_ctrl_pkg`:
  - State enum `alu_ctrl_state_t` (3-bit, encodings above).
  - Opcode struct `alu_op_t` {arith, sel[2:0]}.
  - Constant `SEL_ADD = 3'b000` (the selector whose carry is meaningful).
- Sub-module `rise_pulse`: edge detector with reset value 1 for `prev`, one instance for `btn_next`.
- The ALU and display decoder are instantiated by the top level, not inside this block.

## Test plan
- Reset with `btn_next` held high → no state change after reset is released; state 0, all outputs 0.
- Sequence sw_data=5 press, sw_data=6 press, sw_op=4'b1000 press → at t+2: `result`=4'b1011 (carry 1, sum 3), `result_valid`=1, state 4, `op_count`=1.
- In SHOW with `chain`=1, press → `alu_a`=3'b011, state 1. Then B=2, sw_op=4'b0000 → `result`=4'b0010 (logic op; upper bit 0 per ALU), `op_count`=2.
- `btn_clear` asserted in EXEC (force via LOAD_OP press then clear next cycle) → state 0, `result_valid`=0, `op_count` unchanged.
- Clear and press in the same cycle in LOAD_B → state 0, `alu_b`=0.
- With `CNT_W`=2, run 5 operations → `op_count` saturates at 3. Hold `btn_next` for 10 cycles → exactly one state advance.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU sequencing controller.
// Holds the FSM state encoding and the packed opcode layout taken from the switches.
package alu_ctrl_pkg;

    typedef enum logic [2:0] {
        LOAD_A  = 3'd0,
        LOAD_B  = 3'd1,
        LOAD_OP = 3'd2,
        EXEC    = 3'd3,
        SHOW    = 3'd4
    } alu_ctrl_state_t;

    typedef struct packed {
        logic       arith;
        logic [2:0] sel;
    } alu_op_t;

    // Only this selector produces a meaningful carry in bit N of the ALU result.
    localparam logic [2:0] SEL_ADD = 3'b000;

endpackage

// File: rtl/rise_pulse.sv
// Rising-edge detector for an already synchronized level.
// prev resets to 1 so that a level held high through reset never produces a pulse.
module rise_pulse (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic pulse
);

    logic prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= 1'b1;
        end else begin
            prev <= sig;
        end
    end

    assign pulse = sig & ~prev;

endmodule

// File: rtl/alu_op_controller.sv
// Sequencer for the board ALU: loads A, B and an opcode one press at a time,
// runs a single EXEC cycle to capture the result, and supports chaining result into A.
module alu_op_controller
    import alu_ctrl_pkg::*;
#(
    parameter int N     = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_next,
    input  logic             btn_clear,
    input  logic             chain,
    input  logic [N-1:0]     sw_data,
    input  logic [3:0]       sw_op,
    input  logic [N:0]       alu_result,
    output logic [N-1:0]     alu_a,
    output logic [N-1:0]     alu_b,
    output logic [2:0]       alu_sel,
    output logic             alu_arith,
    output logic [N:0]       result,
    output logic             result_valid,
    output logic [2:0]       state_code,
    output logic [CNT_W-1:0] op_count
);

    alu_ctrl_state_t state;
    alu_op_t         op_in;
    alu_op_t         op_q;
    logic            press;

    rise_pulse u_next_pulse (
        .clk   (clk),
        .rst   (rst),
        .sig   (btn_next),
        .pulse (press)
    );

    assign op_in      = alu_op_t'(sw_op);
    assign alu_sel    = op_q.sel;
    assign alu_arith  = op_q.arith;
    assign state_code = state;

    // NOTE: every register here is written with <= so all fields update together on
    // the edge; a blocking write would let later statements see the new value early.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= LOAD_A;
            alu_a        <= '0;
            alu_b        <= '0;
            op_q         <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            op_count     <= '0;
        end else if (btn_clear) begin
            // Abort wins over any press this cycle; the operation counter survives.
            state        <= LOAD_A;
            alu_a        <= '0;
            alu_b        <= '0;
            op_q         <= '0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            case (state)
                LOAD_A: begin
                    if (press) begin
                        alu_a <= sw_data;
                        state <= LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (press) begin
                        alu_b <= sw_data;
                        state <= LOAD_OP;
                    end
                end
                LOAD_OP: begin
                    if (press) begin
                        op_q         <= op_in;
                        result_valid <= 1'b0;
                        state        <= EXEC;
                    end
                end
                EXEC: begin
                    result       <= alu_result;
                    result_valid <= 1'b1;
                    if (op_count != {CNT_W{1'b1}}) begin
                        op_count <= op_count + CNT_W'(1);
                    end
                    state <= SHOW;
                end
                SHOW: begin
                    if (press) begin
                        if (chain) begin
                            alu_a <= result[N-1:0];
                            state <= LOAD_B;
                        end else begin
                            state <= LOAD_A;
                        end
                    end
                end
                default: begin
                    state <= LOAD_A;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_controller.sv
// Self-checking bench for alu_op_controller: directed scenarios plus randomized
// operation sequences checked against a transaction-level model of the expected results.
module tb_alu_op_controller;
    localparam int N     = 3;
    localparam int CNT_W = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             btn_next;
    logic             btn_clear;
    logic             chain;
    logic [N-1:0]     sw_data;
    logic [3:0]       sw_op;
    logic [N:0]       alu_result;
    logic [N-1:0]     alu_a;
    logic [N-1:0]     alu_b;
    logic [2:0]       alu_sel;
    logic             alu_arith;
    logic [N:0]       result;
    logic             result_valid;
    logic [2:0]       state_code;
    logic [CNT_W-1:0] op_count;

    int vectors    = 0;
    int miscompares = 0;
    int exp_count  = 0;
    logic [N:0] exp_result;

    alu_op_controller #(.N(N), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_next     (btn_next),
        .btn_clear    (btn_clear),
        .chain        (chain),
        .sw_data      (sw_data),
        .sw_op        (sw_op),
        .alu_result   (alu_result),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_sel      (alu_sel),
        .alu_arith    (alu_arith),
        .result       (result),
        .result_valid (result_valid),
        .state_code   (state_code),
        .op_count     (op_count)
    );

    always #5 clk = ~clk;

    // Board ALU stand-in: add with carry, subtract, and a few logic functions.
    function automatic logic [N:0] alu_fn(input logic [N-1:0] a, input logic [N-1:0] b,
                                          input logic arith, input logic [2:0] sel);
        logic [N:0] r;
        if (arith) begin
            case (sel)
                3'b000:  r = {1'b0, a} + {1'b0, b};
                3'b001:  r = {1'b0, a - b};
                default: r = {1'b0, a};
            endcase
        end else begin
            case (sel)
                3'b000:  r = {1'b0, a & b};
                3'b001:  r = {1'b0, a | b};
                3'b010:  r = {1'b0, a ^ b};
                3'b011:  r = {1'b0, ~a};
                default: r = {1'b0, a};
            endcase
        end
        return r;
    endfunction

    always_comb alu_result = alu_fn(alu_a, alu_b, alu_arith, alu_sel);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press();
        btn_next = 1'b1;
        tick();
        btn_next = 1'b0;
        tick();
    endtask

    task automatic bump_count();
        if (exp_count < CNT_MAX) exp_count++;
    endtask

    task automatic test_reset();
        rst = 1'b1; btn_next = 1'b1; btn_clear = 1'b0; chain = 1'b0;
        sw_data = 3'd7; sw_op = 4'hF;
        repeat (3) tick();
        rst = 1'b0;
        repeat (3) tick();
        vectors++;
        if ({state_code, alu_a, alu_b, alu_sel, alu_arith, result, result_valid, op_count} !== '0) begin
            miscompares++;
            $display("FAIL reset_held_btn: state=%0d a=%0d b=%0d sel=%0d ar=%0d res=%0d v=%0d cnt=%0d expected all 0",
                     state_code, alu_a, alu_b, alu_sel, alu_arith, result, result_valid, op_count);
        end
        btn_next = 1'b0;
        tick();
        exp_count = 0;
    endtask

    task automatic test_basic_add();
        sw_data = 3'd5; press();
        vectors++;
        if ({state_code, alu_a} !== {3'd1, 3'd5}) begin
            miscompares++;
            $display("FAIL load_a: state=%0d a=%0d expected state=1 a=5", state_code, alu_a);
        end
        sw_data = 3'd6; press();
        vectors++;
        if ({state_code, alu_b} !== {3'd2, 3'd6}) begin
            miscompares++;
            $display("FAIL load_b: state=%0d b=%0d expected state=2 b=6", state_code, alu_b);
        end
        sw_op = 4'b1000; btn_next = 1'b1; tick();
        vectors++;
        if ({state_code, alu_arith, alu_sel, result_valid} !== {3'd3, 1'b1, 3'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL exec_entry: state=%0d ar=%0d sel=%0d v=%0d expected state=3 ar=1 sel=0 v=0",
                     state_code, alu_arith, alu_sel, result_valid);
        end
        btn_next = 1'b0; tick();
        bump_count();
        vectors++;
        if ({result, result_valid, state_code, op_count} !== {4'b1011, 1'b1, 3'd4, CNT_W'(exp_count)}) begin
            miscompares++;
            $display("FAIL add_result: res=%b v=%0d state=%0d cnt=%0d expected res=1011 v=1 state=4 cnt=%0d",
                     result, result_valid, state_code, op_count, exp_count);
        end
    endtask

    task automatic test_chain();
        chain = 1'b1; press(); chain = 1'b0;
        vectors++;
        if ({alu_a, state_code, result, result_valid} !== {3'b011, 3'd1, 4'b1011, 1'b1}) begin
            miscompares++;
            $display("FAIL chain_press: a=%b state=%0d res=%b v=%0d expected a=011 state=1 res=1011 v=1",
                     alu_a, state_code, result, result_valid);
        end
        sw_data = 3'd2; press();
        sw_op = 4'b0000; press();
        bump_count();
        vectors++;
        if ({result, result_valid, state_code, op_count} !== {4'b0010, 1'b1, 3'd4, CNT_W'(exp_count)}) begin
            miscompares++;
            $display("FAIL chain_and: res=%b v=%0d state=%0d cnt=%0d expected res=0010 v=1 state=4 cnt=%0d",
                     result, result_valid, state_code, op_count, exp_count);
        end
    endtask

    task automatic test_clear_exec();
        chain = 1'b0; press();
        sw_data = 3'd1; press();
        sw_data = 3'd3; press();
        sw_op = 4'b1000; btn_next = 1'b1; tick();
        btn_next = 1'b0; btn_clear = 1'b1; tick();
        vectors++;
        if ({state_code, result_valid, result, alu_a, alu_b, op_count} !== {3'd0, 1'b0, 4'd0, 3'd0, 3'd0, CNT_W'(exp_count)}) begin
            miscompares++;
            $display("FAIL clear_in_exec: state=%0d v=%0d res=%0d a=%0d b=%0d cnt=%0d expected 0 0 0 0 0 cnt=%0d",
                     state_code, result_valid, result, alu_a, alu_b, op_count, exp_count);
        end
        btn_clear = 1'b0; tick();
    endtask

    task automatic test_clear_press();
        sw_data = 3'd7; press();
        sw_data = 3'd5; btn_next = 1'b1; btn_clear = 1'b1; tick();
        vectors++;
        if ({state_code, alu_a, alu_b} !== {3'd0, 3'd0, 3'd0}) begin
            miscompares++;
            $display("FAIL clear_with_press: state=%0d a=%0d b=%0d expected state=0 a=0 b=0",
                     state_code, alu_a, alu_b);
        end
        btn_next = 1'b0; btn_clear = 1'b0; tick();
        vectors++;
        if (state_code !== 3'd0) begin
            miscompares++;
            $display("FAIL clear_settle: state=%0d expected 0", state_code);
        end
    endtask

    task automatic test_random_ops(input int iters);
        logic [N-1:0] a, b;
        logic [3:0]   op;
        logic         chained = 1'b0;
        logic         do_chain;
        for (int i = 0; i < iters; i++) begin
            if (chained) begin
                a = exp_result[N-1:0];
            end else begin
                a = N'($urandom);
                sw_data = a; press();
                vectors++;
                if ({state_code, alu_a} !== {3'd1, a}) begin
                    miscompares++;
                    $display("FAIL rnd_load_a[%0d]: state=%0d a=%0d expected state=1 a=%0d", i, state_code, alu_a, a);
                end
            end
            b = N'($urandom);
            sw_data = b; press();
            vectors++;
            if ({state_code, alu_b} !== {3'd2, b}) begin
                miscompares++;
                $display("FAIL rnd_load_b[%0d]: state=%0d b=%0d expected state=2 b=%0d", i, state_code, alu_b, b);
            end
            op = 4'($urandom);
            sw_op = op; btn_next = 1'b1; tick();
            vectors++;
            if ({state_code, alu_arith, alu_sel} !== {3'd3, op}) begin
                miscompares++;
                $display("FAIL rnd_opcode[%0d]: state=%0d op=%b expected state=3 op=%b",
                         i, state_code, {alu_arith, alu_sel}, op);
            end
            btn_next = 1'b0; tick();
            exp_result = alu_fn(a, b, op[3], op[2:0]);
            bump_count();
            vectors++;
            if ({result, result_valid, state_code, op_count} !== {exp_result, 1'b1, 3'd4, CNT_W'(exp_count)}) begin
                miscompares++;
                $display("FAIL rnd_result[%0d]: res=%b v=%0d state=%0d cnt=%0d expected res=%b v=1 state=4 cnt=%0d",
                         i, result, result_valid, state_code, op_count, exp_result, exp_count);
            end
            do_chain = (i == iters - 1) ? 1'b0 : 1'($urandom);
            chain = do_chain; press(); chain = 1'b0;
            vectors++;
            if (do_chain) begin
                if ({state_code, alu_a, result, result_valid} !== {3'd1, exp_result[N-1:0], exp_result, 1'b1}) begin
                    miscompares++;
                    $display("FAIL rnd_chain[%0d]: state=%0d a=%0d res=%b v=%0d expected state=1 a=%0d res=%b v=1",
                             i, state_code, alu_a, result, result_valid, exp_result[N-1:0], exp_result);
                end
            end else begin
                if ({state_code, result, result_valid} !== {3'd0, exp_result, 1'b1}) begin
                    miscompares++;
                    $display("FAIL rnd_nochain[%0d]: state=%0d res=%b v=%0d expected state=0 res=%b v=1",
                             i, state_code, result, result_valid, exp_result);
                end
            end
            chained = do_chain;
        end
    endtask

    task automatic test_hold_button();
        sw_data = 3'd4;
        btn_next = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            vectors++;
            if (state_code !== 3'd1) begin
                miscompares++;
                $display("FAIL hold_btn[%0d]: state=%0d expected 1", i, state_code);
            end
        end
        btn_next = 1'b0; tick();
        vectors++;
        if ({state_code, alu_a} !== {3'd1, 3'd4}) begin
            miscompares++;
            $display("FAIL hold_release: state=%0d a=%0d expected state=1 a=4", state_code, alu_a);
        end
    endtask

    task automatic test_reset_mid();
        sw_data = 3'd6; press();
        rst = 1'b1; tick();
        rst = 1'b0; tick();
        exp_count = 0;
        vectors++;
        if ({state_code, alu_a, alu_b, alu_sel, alu_arith, result, result_valid, op_count} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid: state=%0d a=%0d b=%0d sel=%0d ar=%0d res=%0d v=%0d cnt=%0d expected all 0",
                     state_code, alu_a, alu_b, alu_sel, alu_arith, result, result_valid, op_count);
        end
    endtask

    initial begin
        test_reset();
        test_basic_add();
        test_chain();
        test_clear_exec();
        test_clear_press();
        test_random_ops(12);
        test_hold_button();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
